// File: rtl/nibble_serial_subtractor_pkg.sv
// sub_pkg: shared nibble width, FSM state type and nibble-count helper for the serial subtractor
package sub_pkg;
   localparam int NIBBLE_W = 4;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   function automatic int nibble_count(input int width);
      return width / NIBBLE_W;
   endfunction
endpackage

// File: rtl/nibble_serial_subtractor_nibble.sv
// sub_nibble: combinational 4-bit borrow-ripple subtract slice
//  a4, b4 : nibble operands      bi : borrow in
//  d4     : a4 - b4 - bi         bo : borrow out of bit 3
//  b3     : borrow into bit 3, used for signed overflow on the top slice
module sub_nibble (
   input  logic [3:0] a4,
   input  logic [3:0] b4,
   input  logic       bi,
   output logic [3:0] d4,
   output logic       bo,
   output logic       b3
);
   assign d4 = a4 - b4 - {3'b0, bi};
   assign bo = {1'b0, a4} < {1'b0, b4} + {4'b0, bi};
   assign b3 = {1'b0, a4[2:0]} < {1'b0, b4[2:0]} + {3'b0, bi};
endmodule

// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: diff = a - b - bin over WIDTH bits, one nibble per clock
//  clk, rst (sync, active-high)
//  in_valid/in_ready, a, b, bin      : operand handshake
//  out_valid/out_ready, diff, bout   : result handshake
//  zero, ovf                         : present only when SUB_FLAGS_EN is defined
module nibble_serial_subtractor
   import sub_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
`ifdef SUB_FLAGS_EN
   output logic             zero,
   output logic             ovf,
`endif
   output logic             bout
);
   localparam int NIBBLES = nibble_count(WIDTH);
   localparam int IW = $clog2(NIBBLES);
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
   state_t state;
   logic [WIDTH-1:0] a_r, b_r, res, res_n;
   logic [IW-1:0] idx;
   logic br, bo;
   logic [3:0] d4;
`ifdef SUB_FLAGS_EN
   logic b3;
`endif
   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   sub_nibble u_slice (
      .a4(a_r[NIBBLE_W*idx +: NIBBLE_W]),
      .b4(b_r[NIBBLE_W*idx +: NIBBLE_W]),
      .bi(br),
      .d4(d4),
      .bo(bo),
`ifdef SUB_FLAGS_EN
      .b3(b3)
`else
      .b3()
`endif
   );
   // res accumulates the in-flight result so diff only changes on entry to DONE
   always_comb begin
      res_n = res;
      res_n[NIBBLE_W*idx +: NIBBLE_W] = d4;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         diff  <= '0;
         bout  <= 1'b0;
`ifdef SUB_FLAGS_EN
         zero  <= 1'b0;
         ovf   <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: if (in_valid) begin
               a_r   <= a;
               b_r   <= b;
               br    <= bin;
               idx   <= '0;
               state <= RUN;
            end
            RUN: begin
               res <= res_n;
               br  <= bo;
               idx <= idx + IW'(1);
               if (idx == LAST) begin
                  diff  <= res_n;
                  bout  <= bo;
`ifdef SUB_FLAGS_EN
                  zero  <= ~|res_n;
                  ovf   <= b3 ^ bo;
`endif
                  state <= DONE;
               end
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb_nibble_serial_subtractor: directed and random self-checking bench for WIDTH=16
module tb_nibble_serial_subtractor;
   logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, bin = 0;
   logic [15:0] a = 0, b = 0;
   logic in_ready, out_valid, bout;
   logic [15:0] diff;
`ifdef SUB_FLAGS_EN
   logic zero, ovf;
`endif
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   nibble_serial_subtractor #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff),
`ifdef SUB_FLAGS_EN
      .zero(zero), .ovf(ovf),
`endif
      .bout(bout)
   );
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic start(input logic [15:0] ta, input logic [15:0] tb, input logic tbin);
      a = ta; b = tb; bin = tbin; in_valid = 1;
      step();
      in_valid = 0;
   endtask
   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         step();
         n++;
      end
   endtask
   task automatic chk_res(input string tag, input logic [15:0] ed, input logic eb, input logic ez, input logic eo);
      chk({tag, "_diff"}, 32'(diff), 32'(ed));
      chk({tag, "_bout"}, 32'(bout), 32'(eb));
`ifdef SUB_FLAGS_EN
      chk({tag, "_zero"}, 32'(zero), 32'(ez));
      chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
      if (ez === 1'bx || eo === 1'bx) $display("unexpected flag input");
`endif
   endtask
   task automatic handshake();
      out_ready = 1;
      step();
      out_ready = 0;
   endtask
   function automatic logic [18:0] model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin);
      logic [16:0] r;
      int s;
      r = {1'b0, ma} - {1'b0, mb} - 17'(mbin);
      s = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
      return {s < -32768 || s > 32767, r[15:0] == 16'h0, r};
   endfunction
   int n, cyc, last, got, issued;
   logic [18:0] e;
   logic [18:0] q[$];
   logic [15:0] held;
   logic phantom;
   initial begin
      step();
      step();
      rst = 0;
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk_res("rst", 16'h0000, 0, 0, 0);
      // basic subtract and latency
      chk("t1_in_ready", 32'(in_ready), 1);
      start(16'h1234, 16'h0234, 0);
      chk("t1_busy", 32'(in_ready), 0);
      wait_valid(n);
      chk("t1_latency", 32'(n), 4);
      chk_res("t1", 16'h1000, 0, 0, 0);
      handshake();
      chk("t1_idle", 32'(in_ready), 1);
      chk("t1_held_diff", 32'(diff), 32'h1000);
      // full-length borrow ripple
      start(16'h0000, 16'h0001, 0);
      wait_valid(n);
      chk("t2_latency", 32'(n), 4);
      chk_res("t2", 16'hFFFF, 1, 0, 0);
      handshake();
      // signed overflow and zero with borrow-in
      start(16'h8000, 16'h0001, 0);
      wait_valid(n);
      chk_res("t3a", 16'h7FFF, 0, 0, 1);
      handshake();
      start(16'h5555, 16'h5554, 1);
      wait_valid(n);
      chk_res("t3b", 16'h0000, 0, 1, 0);
      handshake();
      // back-pressure: result held, in_valid ignored
      start(16'h00A0, 16'h0005, 0);
      wait_valid(n);
      chk("t4_latency", 32'(n), 4);
      for (int i = 0; i < 6; i++) begin
         in_valid = i[0];
         a = 16'($urandom);
         b = 16'($urandom);
         step();
         chk("t4_out_valid", 32'(out_valid), 1);
         chk("t4_in_ready", 32'(in_ready), 0);
         chk("t4_diff", 32'(diff), 32'h009B);
         chk("t4_bout", 32'(bout), 0);
      end
      in_valid = 0;
      handshake();
      chk("t4_out_valid_low", 32'(out_valid), 0);
      chk("t4_in_ready_high", 32'(in_ready), 1);
      phantom = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         phantom |= out_valid | ~in_ready;
      end
      chk("t4_no_phantom_op", 32'(phantom), 0);
      chk("t4_held_diff", 32'(diff), 32'h009B);
      // reset mid-operation
      start(16'hFFFF, 16'h1234, 0);
      step();
      step();
      rst = 1;
      step();
      rst = 0;
      chk("t5_out_valid", 32'(out_valid), 0);
      chk("t5_in_ready", 32'(in_ready), 1);
      chk_res("t5_rst", 16'h0000, 0, 0, 0);
      wait_valid(n);
      chk("t5_discarded", 32'(out_valid), 0);
      start(16'h00FF, 16'h000F, 0);
      wait_valid(n);
      chk("t5_latency", 32'(n), 4);
      chk_res("t5", 16'h00F0, 0, 0, 0);
      handshake();
      // random back-to-back stream
      out_ready = 1;
      cyc = 0; last = -1; got = 0; issued = 0;
      while (got < 100 && cyc < 1000) begin
         if (out_valid) begin
            if (q.size() == 0) chk("rnd_spurious", 32'(out_valid), 0);
            else begin
               e = q.pop_front();
               chk_res("rnd", e[15:0], e[16], e[17], e[18]);
               if (last >= 0) chk("rnd_gap", 32'(cyc - last), 6);
            end
            last = cyc;
            got++;
         end
         in_valid = in_ready && issued < 100;
         if (in_valid) begin
            a = 16'($urandom);
            b = 16'($urandom);
            bin = 1'($urandom);
            q.push_back(model(a, b, bin));
            issued++;
         end
         step();
         cyc++;
      end
      in_valid = 0;
      out_ready = 0;
      chk("rnd_count", 32'(got), 100);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
